// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TO_W_DEF    = 8;
  localparam int TIMEOUT_DEF = 200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on a tie the port that did not win last time is chosen.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (req0 && req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of memory_system.
// Issues one enable pulse per transaction, returns data with ack, or err on a hang.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TO_W    = TO_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rd_wrt0,
  input  logic              rd_wrt1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ms_enable,
  output logic              ms_rd_wrt,
  output logic [ADDR_W-1:0] ms_addr,
  output logic [DATA_W-1:0] ms_data_in,
  input  logic              ms_idle,
  input  logic              ms_done,
  input  logic [DATA_W-1:0] ms_data_out
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              gnt_valid, gnt_id;

  logic              ack0_d, ack1_d, err0_d, err1_d, busy_d;
  logic              ms_enable_d, ms_rd_wrt_d;
  logic [ADDR_W-1:0] ms_addr_d;
  logic [DATA_W-1:0] ms_data_in_d, rdata_d;

  rr_arb2 u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    ms_enable_d  = 1'b0;
    ms_rd_wrt_d  = ms_rd_wrt;
    ms_addr_d    = ms_addr;
    ms_data_in_d = ms_data_in;
    rdata_d      = rdata;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // The cycle carrying err is the one where the aborted requester still
        // holds req; granting then would restart the transaction it is dropping.
        if (gnt_valid && ms_idle && !(err0 || err1)) begin
          state_d      = ISSUE;
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          ms_enable_d  = 1'b1;
          ms_rd_wrt_d  = gnt_id ? rd_wrt1 : rd_wrt0;
          ms_addr_d    = gnt_id ? addr1 : addr0;
          ms_data_in_d = gnt_id ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (ms_done) begin
          rdata_d = ms_data_out;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ms_done) begin
          rdata_d = ms_data_out;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          err0_d  = ~owner_q;
          err1_d  = owner_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      ms_enable    <= 1'b0;
      ms_rd_wrt    <= 1'b0;
      ms_addr      <= '0;
      ms_data_in   <= '0;
      rdata        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      ms_enable    <= ms_enable_d;
      ms_rd_wrt    <= ms_rd_wrt_d;
      ms_addr      <= ms_addr_d;
      ms_data_in   <= ms_data_in_d;
      rdata        <= rdata_d;
      ack0         <= ack0_d;
      ack1         <= ack1_d;
      err0         <= err0_d;
      err1         <= err1_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, issue/response scoreboard, vector table and corner sequences.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 200;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 1'b0, req1 = 1'b0, rd_wrt0 = 1'b0, rd_wrt1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1, busy;
  logic [DW-1:0] rdata;
  logic          ms_enable, ms_rd_wrt;
  logic [AW-1:0] ms_addr;
  logic [DW-1:0] ms_data_in;
  logic          ms_idle = 1'b1, ms_done = 1'b0;
  logic [DW-1:0] ms_data_out = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TO_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rd_wrt0(rd_wrt0), .rd_wrt1(rd_wrt1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy),
    .ms_enable(ms_enable), .ms_rd_wrt(ms_rd_wrt), .ms_addr(ms_addr), .ms_data_in(ms_data_in),
    .ms_idle(ms_idle), .ms_done(ms_done), .ms_data_out(ms_data_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // memory model: done after mem_lat cycles (0 = during ISSUE), data = address ^ mem_key
  int            mem_lat  = 1;
  logic          mem_hang = 1'b0;
  logic [DW-1:0] mem_key  = '0;
  int            cd       = -1;

  always @(negedge clk) begin
    ms_done     = 1'b0;
    ms_data_out = DW'($urandom);
    if (!rst) begin
      cd = -1;
    end else if (ms_enable) begin
      if (mem_hang) cd = -1;
      else if (mem_lat == 0) begin
        ms_done = 1'b1; ms_data_out = ms_addr ^ mem_key; cd = -1;
      end else cd = mem_lat;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        ms_done = 1'b1; ms_data_out = ms_addr ^ mem_key; cd = -1;
      end
    end
  end

  // scoreboard
  logic [32:0] exp_iss_q[$];  // {rd_wrt, addr, wdata}
  logic [19:0] exp_q[$];      // {err1, err0, ack1, ack0, rdata}

  always @(negedge clk) begin
    if (rst) begin
      if (ms_enable) begin
        if (exp_iss_q.size() == 0) check("unexpected_ms_enable", 1, 0);
        else check("issue", {ms_rd_wrt, ms_addr, ms_data_in}, exp_iss_q.pop_front());
      end
      if (ack0 | ack1 | err0 | err1) begin
        check("ack_err_onehot", 64'($onehot({ack0, ack1, err0, err1})), 1);
        if (exp_q.size() == 0) check("unexpected_response", 1, 0);
        else check("response", {err1, err0, ack1, ack0, rdata}, exp_q.pop_front());
      end
    end
  end

  logic          last_m       = 1'b1;
  logic [DW-1:0] last_rdata_m = '0;

  task automatic expect_txn(input logic port, input logic rw, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [1:0] ea, input logic [1:0] ee,
                            input logic [DW-1:0] er);
    exp_iss_q.push_back({rw, a, wd});
    exp_q.push_back({ee, ea, er});
    last_m = port;
    if (ea != 2'b00) last_rdata_m = er;
  endtask

  task automatic drive_req(input logic port, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd);
    if (port) begin rd_wrt1 = rw; addr1 = a; wdata1 = wd; req1 = 1'b1; end
    else      begin rd_wrt0 = rw; addr0 = a; wdata0 = wd; req0 = 1'b1; end
  endtask

  task automatic drop_req(input logic port);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  task automatic wait_issue(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (ms_enable) begin n = i; break; end
    end
    if (n == 0) check("issue_timeout", 0, 1);
  endtask

  task automatic wait_resp(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (ack0 | ack1 | err0 | err1) begin n = i; break; end
    end
    if (n == 0) check("response_timeout", 0, 1);
  endtask

  task automatic run_txn(input logic port, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] key, input int lat,
                         input logic [1:0] ea, input logic [DW-1:0] er);
    int n;
    mem_key = key;
    mem_lat = lat;
    expect_txn(port, rw, a, wd, ea, 2'b00, er);
    drive_req(port, rw, a, wd);
    wait_resp(300, n);
    drop_req(port);
  endtask

  typedef struct {
    logic          port;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] key;
    int            lat;
    logic [1:0]    exp_ack;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    // vector table: {inputs, expected ack/rdata}
    vecs[0] = '{port: 1'b0, rw: 1'b1, addr: 16'h0040, wdata: 16'h0000, key: 16'hBEAF, lat: 1,
                exp_ack: 2'b01, exp_rdata: 16'hBEEF};
    vecs[1] = '{port: 1'b1, rw: 1'b0, addr: 16'h1234, wdata: 16'h5A5A, key: 16'h0000, lat: 3,
                exp_ack: 2'b10, exp_rdata: 16'h1234};
    vecs[2] = '{port: 1'b0, rw: 1'b1, addr: 16'hFFFF, wdata: 16'h0000, key: 16'hFFFF, lat: 0,
                exp_ack: 2'b01, exp_rdata: 16'h0000};
    vecs[3] = '{port: 1'b1, rw: 1'b1, addr: 16'h0000, wdata: 16'hFFFF, key: 16'h1111, lat: 2,
                exp_ack: 2'b10, exp_rdata: 16'h1111};
    for (int i = 4; i < 6; i++) begin
      vecs[i].port      = 1'($urandom_range(0, 1));
      vecs[i].rw        = 1'($urandom_range(0, 1));
      vecs[i].addr      = AW'($urandom);
      vecs[i].wdata     = DW'($urandom);
      vecs[i].key       = DW'($urandom);
      vecs[i].lat       = $urandom_range(1, 8);
      vecs[i].exp_ack   = vecs[i].port ? 2'b10 : 2'b01;
      vecs[i].exp_rdata = vecs[i].addr ^ vecs[i].key;
    end

    // reset held with a pending request: everything stays 0
    drive_req(1'b0, 1'b1, 16'h0100, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs_zero",
            {ms_enable, ms_rd_wrt, ms_addr, ms_data_in, ack0, ack1, err0, err1, rdata, busy}, 0);
    end
    mem_key = '0;
    mem_lat = 1;
    expect_txn(1'b0, 1'b1, 16'h0100, 16'h0000, 2'b01, 2'b00, 16'h0100);
    rst = 1'b1;
    @(negedge clk);
    check("first_enable_latency", {ms_enable, busy}, 2'b11);
    wait_resp(20, n);
    drop_req(1'b0);

    // vector table
    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].key,
              vecs[i].lat, vecs[i].exp_ack, vecs[i].exp_rdata);

    // write on port 1: ms_* stable while waiting, later input changes ignored
    mem_key = 16'h0F0F;
    mem_lat = 6;
    expect_txn(1'b1, 1'b0, 16'h1234, 16'h5A5A, 2'b10, 2'b00, 16'h1234 ^ 16'h0F0F);
    drive_req(1'b1, 1'b0, 16'h1234, 16'h5A5A);
    wait_issue(10, n);
    addr1 = 16'hDEAD; wdata1 = 16'hC0DE; rd_wrt1 = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack0 | ack1 | err0 | err1) begin n = i; break; end
      check("write_ms_stable", {ms_rd_wrt, ms_addr, ms_data_in}, {1'b0, 16'h1234, 16'h5A5A});
    end
    if (n == 0) check("response_timeout", 0, 1);
    drop_req(1'b1);

    // timeout: err0 TIMEOUT cycles after entering WAIT, rdata unchanged
    mem_hang = 1'b1;
    expect_txn(1'b0, 1'b1, 16'h0200, 16'h0000, 2'b00, 2'b01, last_rdata_m);
    drive_req(1'b0, 1'b1, 16'h0200, 16'h0000);
    wait_issue(10, n);
    wait_resp(TMO + 20, n);
    check("timeout_latency", n, TMO + 1);
    drop_req(1'b0);
    mem_hang = 1'b0;
    run_txn(1'b0, 1'b1, 16'h0300, 16'h0000, 16'h00FF, 2, 2'b01, 16'h03FF);

    // blocked by ms_idle, then requester abandons during WAIT
    mem_key = 16'h4444;
    mem_lat = 4;
    ms_idle = 1'b0;
    expect_txn(1'b1, 1'b1, 16'h0500, 16'h0000, 2'b10, 2'b00, 16'h4144);
    drive_req(1'b1, 1'b1, 16'h0500, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("blocked_no_grant", {ms_enable, busy}, 2'b00);
    end
    ms_idle = 1'b1;
    wait_issue(10, n);
    @(negedge clk);
    drop_req(1'b1);
    wait_resp(20, n);

    // contention: both held for 4 transactions, expected order from round-robin model
    mem_key = 16'h00FF;
    mem_lat = 2;
    for (int k = 0; k < 4; k++) begin
      if (!last_m) expect_txn(1'b1, 1'b0, 16'h0B00, 16'h7777, 2'b10, 2'b00, 16'h0BFF);
      else         expect_txn(1'b0, 1'b1, 16'h0A00, 16'h1111, 2'b01, 2'b00, 16'h0AFF);
    end
    drive_req(1'b0, 1'b1, 16'h0A00, 16'h1111);
    drive_req(1'b1, 1'b0, 16'h0B00, 16'h7777);
    for (int k = 0; k < 4; k++) wait_resp(30, n);
    drop_req(1'b0);
    drop_req(1'b1);

    repeat (4) @(negedge clk);
    check("issue_queue_drained", exp_iss_q.size(), 0);
    check("response_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
